multiply_unit: RTL and testbench

- Integer multiplier for the neocore execute stage; serves UMULL (unsigned) and SMULL (signed) instructions.
- Takes two DATA_W-bit operands and returns the full 2*DATA_W-bit product, split into low and high halves.
- Single registered stage: the product of operands present at a rising clock edge is visible on the outputs just after that edge.

---
 rtl/neocore_pkg.sv | 15 +
 rtl/multiply_unit_mul_core.sv | 36 +++
 rtl/multiply_unit.sv | 100 ++++++++++
 tb/tb_multiply_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/neocore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neocore_pkg
// Description : Shared constants for the neocore execute-stage datapath.
//               DATA_W_DEF  - default operand width of the integer units.
//               PROD_W_DEF  - width of a full product (2 * DATA_W_DEF).
// Revision    : 1.0 - initial release
// ============================================================================
package neocore_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PROD_W_DEF = 2 * DATA_W_DEF;

endpackage : neocore_pkg
`default_nettype wire

// File: rtl/multiply_unit_mul_core.sv
`default_nettype none
// ============================================================================
// Module      : mul_core
// Description : Combinational signed multiplier. Both inputs are already
//               extended by one bit (sign or zero) so a single signed multiply
//               serves signed and unsigned products alike. Only the low
//               2*DATA_W bits are returned; they are exact for any
//               combination of extended operands.
// Ports       : i_a    [DATA_W:0]      extended multiplicand (signed)
//               i_b    [DATA_W:0]      extended multiplier   (signed)
//               o_prod [2*DATA_W-1:0]  product (signed)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_core
    import neocore_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W:0]     i_a,
    input  logic signed [DATA_W:0]     i_b,
    output logic signed [2*DATA_W-1:0] o_prod
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] w_a_x;
    logic signed [PROD_W-1:0] w_b_x;

    // Sign-extend to the product width first; multiplying modulo 2^PROD_W then
    // yields exactly the low PROD_W bits of the (DATA_W+1)x(DATA_W+1) product.
    assign w_a_x  = PROD_W'(i_a);
    assign w_b_x  = PROD_W'(i_b);
    assign o_prod = w_a_x * w_b_x;

endmodule : mul_core
`default_nettype wire

// File: rtl/multiply_unit.sv
`default_nettype none
// ============================================================================
// Module      : multiply_unit
// Description : Single-stage registered integer multiplier (UMULL / SMULL).
//               Operands are extended by one bit according to is_signed,
//               multiplied in mul_core, and the full 2*DATA_W product is
//               registered into result_hi:result_lo with one cycle latency.
// Ports       : clk        system clock, rising edge
//               rst        asynchronous reset, active low
//               operand_a  [DATA_W-1:0] multiplicand
//               operand_b  [DATA_W-1:0] multiplier
//               is_signed  1 = two's-complement, 0 = unsigned
//               result_lo  [DATA_W-1:0] product low half  (registered)
//               result_hi  [DATA_W-1:0] product high half (registered)
//               result_zero / result_neg (only with MULTIPLY_UNIT_FLAGS_EN)
// Config      : `define MULTIPLY_UNIT_FLAGS_EN adds the zero/negative flags.
// Revision    : 1.0 - initial release
// ============================================================================
module multiply_unit
    import neocore_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              is_signed,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi
`ifdef MULTIPLY_UNIT_FLAGS_EN
    ,
    output logic              result_zero,
    output logic              result_neg
`endif
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [DATA_W:0]   w_ext_a;
    logic signed [DATA_W:0]   w_ext_b;
    logic signed [PROD_W-1:0] w_prod;
    logic        [PROD_W-1:0] result_d;
    logic        [PROD_W-1:0] result_q;

    // Extension bit: copy of the MSB for signed, zero for unsigned.
    assign w_ext_a = {is_signed & operand_a[DATA_W-1], operand_a};
    assign w_ext_b = {is_signed & operand_b[DATA_W-1], operand_b};

    mul_core #(
        .DATA_W (DATA_W)
    ) u_mul_core (
        .i_a    (w_ext_a),
        .i_b    (w_ext_b),
        .o_prod (w_prod)
    );

    always_comb begin
        result_d = w_prod;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result_lo = result_q[DATA_W-1:0];
    assign result_hi = result_q[PROD_W-1:DATA_W];

`ifdef MULTIPLY_UNIT_FLAGS_EN
    logic result_zero_d;
    logic result_zero_q;
    logic result_neg_d;
    logic result_neg_q;

    always_comb begin
        result_zero_d = (w_prod == '0);
        // Negative only has meaning for a signed operation.
        result_neg_d  = is_signed & w_prod[PROD_W-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_zero_q <= 1'b0;
            result_neg_q  <= 1'b0;
        end else begin
            result_zero_q <= result_zero_d;
            result_neg_q  <= result_neg_d;
        end
    end

    assign result_zero = result_zero_q;
    assign result_neg  = result_neg_q;
`endif

endmodule : multiply_unit
`default_nettype wire

// File: tb/tb_multiply_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiply_unit
// Description : Self-checking bench for multiply_unit (DATA_W = 16):
//               reset behaviour, directed vector table, mid-cycle input
//               changes, asynchronous reset, and random operands compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiply_unit;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] operand_a = '0;
    logic [DATA_W-1:0] operand_b = '0;
    logic              is_signed = 1'b0;
    logic [DATA_W-1:0] result_lo;
    logic [DATA_W-1:0] result_hi;
`ifdef MULTIPLY_UNIT_FLAGS_EN
    logic              result_zero;
    logic              result_neg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiply_unit #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .is_signed (is_signed),
        .result_lo (result_lo),
        .result_hi (result_hi)
`ifdef MULTIPLY_UNIT_FLAGS_EN
        ,
        .result_zero (result_zero),
        .result_neg  (result_neg)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] expect_p;
    } vec_t;

    vec_t vecs[12];

    // Reference: interpret operands as plain integers and multiply.
    function automatic logic [31:0] ref_prod(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic        s);
        longint x;
        longint y;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        return 32'(x * y);
    endfunction

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp_v);
        end
    endtask

    // Drive inputs on the falling edge, return 1 ns after the capturing edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        operand_a = a;
        operand_b = b;
        is_signed = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] p;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;

        vecs[0]  = '{16'h0005, 16'h0007, 1'b0, 32'h0000_0023};
        vecs[1]  = '{16'h0100, 16'h0200, 1'b0, 32'h0002_0000};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
        vecs[3]  = '{16'hFFFB, 16'h0007, 1'b1, 32'hFFFF_FFDD};
        vecs[4]  = '{16'hFF9C, 16'h00C8, 1'b1, 32'hFFFF_B1E0};
        vecs[5]  = '{16'h0005, 16'h0007, 1'b1, 32'h0000_0023};
        vecs[6]  = '{16'hFFFB, 16'hFFF9, 1'b1, 32'h0000_0023};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
        vecs[8]  = '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
        vecs[9]  = '{16'h0000, 16'h1234, 1'b0, 32'h0000_0000};
        vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{16'hFFFF, 16'h0002, 1'b0, 32'h0001_FFFE};

        // Reset held: outputs stay zero across edges.
        operand_a = 16'h1234;
        operand_b = 16'h5678;
        is_signed = 1'b0;
        #1;
        check32("reset_initial", {result_hi, result_lo}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check32("reset_hold", {result_hi, result_lo}, 32'h0);
        end
`ifdef MULTIPLY_UNIT_FLAGS_EN
        check1("reset_zero_flag", result_zero, 1'b0);
        check1("reset_neg_flag", result_neg, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("reset_release", {result_hi, result_lo}, 32'h0626_0060);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].s);
            check32($sformatf("vec%0d", i), {result_hi, result_lo}, vecs[i].expect_p);
        end

        // Mode sensitivity and mid-cycle changes.
        apply(16'hFFFF, 16'h0002, 1'b0);
        check32("mode_unsigned", {result_hi, result_lo}, 32'h0001_FFFE);
        #1;
        is_signed = 1'b1;
        #2;
        check32("midcycle_hold", {result_hi, result_lo}, 32'h0001_FFFE);
        @(posedge clk);
        #1;
        check32("mode_signed", {result_hi, result_lo}, 32'hFFFF_FFFE);

`ifdef MULTIPLY_UNIT_FLAGS_EN
        apply(16'h0000, 16'h1234, 1'b0);
        check1("flag_zero", result_zero, 1'b1);
        check1("flag_zero_neg", result_neg, 1'b0);
        apply(16'hFFFB, 16'h0007, 1'b1);
        check1("flag_neg", result_neg, 1'b1);
        check1("flag_neg_zero", result_zero, 1'b0);
        apply(16'hFFFF, 16'hFFFF, 1'b0);
        check1("flag_unsigned_neg", result_neg, 1'b0);
`endif

        // Asynchronous reset in the middle of a cycle.
        apply(16'h1234, 16'h5678, 1'b0);
        check32("pre_async", {result_hi, result_lo}, 32'h0626_0060);
        #2;
        rst = 1'b0;
        #1;
        check32("async_reset", {result_hi, result_lo}, 32'h0);
        @(posedge clk);
        #1;
        check32("async_reset_hold", {result_hi, result_lo}, 32'h0);
        @(negedge clk);
        operand_a = 16'h0005;
        operand_b = 16'h0007;
        is_signed = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check32("async_release", {result_hi, result_lo}, 32'h0000_0023);

        // Random operands against the reference model.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i % 17 == 0) ra = 16'h8000;
            if (i % 23 == 0) rb = 16'h0000;
            apply(ra, rb, rs);
            p = ref_prod(ra, rb, rs);
            check32($sformatf("rand%0d_%h_%h_%b", i, ra, rb, rs),
                    {result_hi, result_lo}, p);
`ifdef MULTIPLY_UNIT_FLAGS_EN
            check1("rand_zero", result_zero, p == 32'h0);
            check1("rand_neg", result_neg, rs & p[31]);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multiply_unit
`default_nettype wire
